// File: rtl/shift_unit_seq.sv
// shift_unit_seq: multi-cycle barrel-shifter replacement for the operand-B path.
// Performs LSL/LSR/ASR/ROR by a register amount, STEP bits per clock, and
// produces the ARM-style shifter carry-out. A valid/ready handshake on both
// sides lets the execute stage stall around it.
// Optional feature macro: SHIFT_RRX_EN (ROR by zero becomes RRX).
module shift_unit_seq #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 8,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             busy
);

    // rem must hold up to WIDTH+1 (LSL/LSR past the end of the word)
    localparam int REM_W = $clog2(WIDTH + 2);
    // comparison width wide enough for both the amount and WIDTH+1
    localparam int CMP_W = ((AMT_W > REM_W) ? AMT_W : REM_W) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_LSL = 2'b00,
        OP_LSR = 2'b01,
        OP_ASR = 2'b10,
        OP_ROR = 2'b11
    } op_t;

    state_t           state_q;
    op_t              op_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             carry_q;
    logic             carry_d;
    logic             sign_q;
    logic             rrx_q;
    logic [REM_W-1:0] rem_q;
    logic             inReady_q;
    logic             outValid_q;
    logic             busy_q;

    logic [CMP_W-1:0] amtExt;
    logic [CMP_W-1:0] effCount;
    logic             acceptCarry;
    logic             acceptRrx;

    logic [REM_W-1:0]   stepAmt;
    logic [WIDTH:0]     lslWide;
    logic [WIDTH:0]     lsrWide;
    logic [2*WIDTH+1:0] asrWide;
    logic [2*WIDTH-1:0] rorWide;

    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign out_data  = data_q;
    assign out_carry = carry_q;
    assign busy      = busy_q;

    // Effective shift count and starting carry for a request being accepted
    always_comb begin
        amtExt      = CMP_W'(in_amt);
        effCount    = '0;
        acceptCarry = in_carry;
        acceptRrx   = 1'b0;
        case (op_t'(in_op))
            OP_LSL, OP_LSR: begin
                effCount = (amtExt > CMP_W'(WIDTH + 1)) ? CMP_W'(WIDTH + 1) : amtExt;
            end
            OP_ASR: begin
                effCount = (amtExt > CMP_W'(WIDTH)) ? CMP_W'(WIDTH) : amtExt;
            end
            default: begin
                effCount = amtExt & CMP_W'(WIDTH - 1);
                // a nonzero multiple of WIDTH leaves the word unchanged but
                // still reports the top bit as the carry
                if ((in_amt != '0) && (effCount == '0)) begin
                    acceptCarry = in_data[WIDTH-1];
                end
`ifdef SHIFT_RRX_EN
                // ROR by zero is RRX: a single one-bit step through the carry
                if (in_amt == '0) begin
                    effCount  = CMP_W'(1);
                    acceptRrx = 1'b1;
                end
`endif
            end
        endcase
    end

    // One BUSY step: shift by min(STEP, rem) and keep the last bit shifted out
    always_comb begin
        stepAmt = (rem_q > REM_W'(STEP)) ? REM_W'(STEP) : rem_q;
        lslWide = {1'b0, data_q} << stepAmt;
        lsrWide = {data_q, 1'b0} >> stepAmt;
        asrWide = {{(WIDTH + 1){sign_q}}, data_q, 1'b0} >> stepAmt;
        rorWide = {data_q, data_q} >> stepAmt;
        data_d  = data_q;
        carry_d = carry_q;
        if (rrx_q) begin
            data_d  = {carry_q, data_q[WIDTH-1:1]};
            carry_d = data_q[0];
        end else begin
            case (op_q)
                OP_LSL: begin
                    data_d  = lslWide[WIDTH-1:0];
                    carry_d = lslWide[WIDTH];
                end
                OP_LSR: begin
                    data_d  = lsrWide[WIDTH:1];
                    carry_d = lsrWide[0];
                end
                OP_ASR: begin
                    data_d  = asrWide[WIDTH:1];
                    carry_d = asrWide[0];
                end
                default: begin
                    data_d  = rorWide[WIDTH-1:0];
                    carry_d = rorWide[WIDTH-1];
                end
            endcase
        end
    end

    // Control FSM with registered handshake outputs; reset aborts any operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= OP_LSL;
            data_q     <= '0;
            carry_q    <= 1'b0;
            sign_q     <= 1'b0;
            rrx_q      <= 1'b0;
            rem_q      <= '0;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q      <= op_t'(in_op);
                        data_q    <= in_data;
                        carry_q   <= acceptCarry;
                        sign_q    <= in_data[WIDTH-1];
                        rrx_q     <= acceptRrx;
                        rem_q     <= REM_W'(effCount);
                        inReady_q <= 1'b0;
                        busy_q    <= 1'b1;
                        if (effCount == '0) begin
                            state_q    <= DONE;
                            outValid_q <= 1'b1;
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    data_q  <= data_d;
                    carry_q <= carry_d;
                    rem_q   <= rem_q - stepAmt;
                    if (rem_q <= REM_W'(STEP)) begin
                        state_q    <= DONE;
                        outValid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q    <= IDLE;
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_unit_seq.sv
// tb_shift_unit_seq: directed, table-driven bench for shift_unit_seq
// (WIDTH=32, AMT_W=8, STEP=4). Expectations follow SHIFT_RRX_EN when defined.
module tb_shift_unit_seq;

    localparam int WIDTH    = 32;
    localparam int AMT_W    = 8;
    localparam int STEP     = 4;
    localparam int MAX_WAIT = 40;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic             in_carry;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic [7:0]  amt;
        logic        cin;
        logic [31:0] expData;
        logic        expCarry;
        int          expLat;
        int          hold;
    } vec_t;

    vec_t vecs[$];

    shift_unit_seq #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W),
        .STEP  (STEP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_carry  (in_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .busy      (busy)
    );

    // free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // absolute safety net so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic [1:0] op, input logic [31:0] data, input logic [7:0] amt,
                          input logic cin, input logic [31:0] expData, input logic expCarry,
                          input int expLat, input int hold);
        vec_t v;
        v.op = op; v.data = data; v.amt = amt; v.cin = cin;
        v.expData = expData; v.expCarry = expCarry; v.expLat = expLat; v.hold = hold;
        vecs.push_back(v);
    endtask

    // run one request: accept, scramble inputs while busy, wait, check, hand off
    task automatic applyStimulus(input vec_t v, input int idx);
        int lat;
        int waitCnt;
        logic [31:0] heldData;
        logic        heldCarry;
        @(negedge clk);
        waitCnt = 0;
        while (!in_ready && waitCnt < MAX_WAIT) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput($sformatf("v%0d_in_ready_before", idx), {31'b0, in_ready}, 32'd1);
        out_ready = (v.hold == 0);
        in_op     = v.op;
        in_data   = v.data;
        in_amt    = v.amt;
        in_carry  = v.cin;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_data  = $urandom;
        in_amt   = 8'($urandom);
        in_op    = 2'($urandom);
        in_carry = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < MAX_WAIT) begin
            checkOutput($sformatf("v%0d_in_ready_busy", idx), {31'b0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        checkOutput($sformatf("v%0d_out_valid", idx), {31'b0, out_valid}, 32'd1);
        checkOutput($sformatf("v%0d_out_data", idx), out_data, v.expData);
        checkOutput($sformatf("v%0d_out_carry", idx), {31'b0, out_carry}, {31'b0, v.expCarry});
        checkOutput($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.expLat));
        checkOutput($sformatf("v%0d_busy_done", idx), {31'b0, busy}, 32'd1);
        heldData  = v.expData;
        heldCarry = v.expCarry;
        for (int k = 0; k < v.hold; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d_hold%0d_valid", idx, k), {31'b0, out_valid}, 32'd1);
            checkOutput($sformatf("v%0d_hold%0d_data", idx, k), out_data, heldData);
            checkOutput($sformatf("v%0d_hold%0d_carry", idx, k), {31'b0, out_carry}, {31'b0, heldCarry});
            checkOutput($sformatf("v%0d_hold%0d_in_ready", idx, k), {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput($sformatf("v%0d_valid_after_handoff", idx), {31'b0, out_valid}, 32'd0);
        checkOutput($sformatf("v%0d_ready_after_handoff", idx), {31'b0, in_ready}, 32'd1);
    endtask

    // reset in the middle of a long LSL must abort with no result emitted
    task automatic midBusyReset();
        int sawValid;
        @(negedge clk);
        in_op = 2'b00; in_data = 32'h0000_0001; in_amt = 8'd20; in_carry = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_busy_before", {31'b0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("rst_mid_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sawValid = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) sawValid++;
        end
        checkOutput("rst_no_output_after", 32'(sawValid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_data   = '0;
        in_amt    = '0;
        in_carry  = 1'b0;
        out_ready = 1'b1;

        //      op     data          amt    cin   expData       c   lat hold
        addVec(2'b00, 32'h8000_0001, 8'd1,   1'b0, 32'h0000_0002, 1'b1, 2,  0);
        addVec(2'b01, 32'h8000_0000, 8'd32,  1'b0, 32'h0000_0000, 1'b1, 9,  0);
        addVec(2'b01, 32'h8000_0000, 8'd33,  1'b1, 32'h0000_0000, 1'b0, 10, 0);
        addVec(2'b10, 32'h8000_0000, 8'd200, 1'b0, 32'hFFFF_FFFF, 1'b1, 9,  0);
        addVec(2'b10, 32'h4000_0000, 8'd31,  1'b0, 32'h0000_0000, 1'b1, 9,  0);
        addVec(2'b11, 32'h0000_00F1, 8'd36,  1'b1, 32'h1000_000F, 1'b0, 2,  5);
        addVec(2'b11, 32'h0000_00F1, 8'd32,  1'b1, 32'h0000_00F1, 1'b0, 1,  0);
        addVec(2'b11, 32'h8000_0000, 8'd64,  1'b0, 32'h8000_0000, 1'b1, 1,  0);
        addVec(2'b00, 32'h1234_5678, 8'd0,   1'b1, 32'h1234_5678, 1'b1, 1,  0);
        addVec(2'b10, 32'h0000_ABCD, 8'd0,   1'b0, 32'h0000_ABCD, 1'b0, 1,  0);
        addVec(2'b00, 32'h0000_0001, 8'd32,  1'b0, 32'h0000_0000, 1'b1, 9,  0);
        addVec(2'b00, 32'hFFFF_FFFF, 8'd33,  1'b1, 32'h0000_0000, 1'b0, 10, 0);
        addVec(2'b01, 32'h0000_000F, 8'd3,   1'b0, 32'h0000_0001, 1'b1, 2,  0);
        addVec(2'b01, 32'h8000_0000, 8'd7,   1'b1, 32'h0100_0000, 1'b0, 3,  0);
        addVec(2'b10, 32'h8000_0010, 8'd5,   1'b0, 32'hFC00_0000, 1'b1, 3,  0);
        addVec(2'b10, 32'h7FFF_FFFF, 8'd40,  1'b1, 32'h0000_0000, 1'b0, 9,  0);
        addVec(2'b11, 32'h1234_5678, 8'd8,   1'b1, 32'h7812_3456, 1'b0, 3,  0);
        addVec(2'b11, 32'h0000_000F, 8'd1,   1'b0, 32'h8000_0007, 1'b1, 2,  0);
`ifdef SHIFT_RRX_EN
        addVec(2'b11, 32'h0000_0003, 8'd0,   1'b1, 32'h8000_0001, 1'b1, 2,  0);
        addVec(2'b11, 32'h0000_0002, 8'd0,   1'b0, 32'h0000_0001, 1'b0, 2,  0);
`else
        addVec(2'b11, 32'h0000_0003, 8'd0,   1'b1, 32'h0000_0003, 1'b1, 1,  0);
        addVec(2'b11, 32'h0000_0002, 8'd0,   1'b0, 32'h0000_0002, 1'b0, 1,  0);
`endif

        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset_out_data", out_data, 32'd0);
        checkOutput("reset_out_carry", {31'b0, out_carry}, 32'd0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        rst_n = 1'b1;

        midBusyReset();

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_unit_seq.md
Name: shift_unit_seq

Overview:
- Parametrised, multi-cycle successor to the combinational register-controlled shifter in the datapath.
- Performs LSL/LSR/ASR/ROR by register amount on WIDTH-bit operands.
- Shifts STEP bits per clock and produces the ARM-style shifter carry-out.
- Sits between register-file read and ALU operand B, with a valid/ready handshake on both sides so the execute stage can stall.

Parameters:
- WIDTH, 32: operand width; power of 2, at least 8.
- AMT_W, 8: width of the shift-amount field; only the low AMT_W bits of the register are used.
- STEP, 4: maximum bits shifted per BUSY cycle; power of 2, 1 to WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_op  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
- in_data  in  WIDTH  operand Rm.
- in_amt  in  AMT_W  shift amount, from Rs[AMT_W-1:0].
- in_carry  in  1  current C flag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  shifted result.
- out_carry  out  1  shifter carry-out.
- busy  out  1  high in BUSY or DONE.

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=1; out_valid=0; out_data=0; out_carry=0; busy=0.
- Reset mid-operation aborts immediately; no result is emitted.
- FSM states IDLE, BUSY, DONE:
  - IDLE: in_ready=1. On in_valid, latch op, data and carry, and compute eff.
  - IDLE exit: go to DONE if eff==0, else to BUSY with rem=eff.
  - BUSY: each cycle shift by s=min(STEP,rem), then rem-=s. Go to DONE when rem<=STEP.
  - DONE: out_valid=1, with out_data/out_carry stable. Return to IDLE on out_ready.
- in_ready is 0 in BUSY and DONE; there is no accept in the same cycle as output handoff.
- Latency from accept edge to out_valid: 1 + ceil(eff/STEP) cycles.
- Effective count eff:
  - LSL/LSR: min(amt, WIDTH+1).
  - ASR: min(amt, WIDTH).
  - ROR: amt mod WIDTH, forced to 0 when amt==0.
- Carry rules. Each step records the last bit shifted out.
  - amt==0, any op: out_data=in_data, out_carry=in_carry.
  - LSL n<=WIDTH: carry=Rm[WIDTH-n]. LSL n>WIDTH: result 0, carry 0.
  - LSR n<=WIDTH: carry=Rm[n-1]. LSR n>WIDTH: result 0, carry 0.
  - ASR n>=WIDTH: result is all Rm[WIDTH-1], carry=Rm[WIDTH-1].
  - ROR with amt!=0: result is the rotation by amt mod WIDTH; carry=result[WIDTH-1]. This includes amt mod WIDTH==0, where result=Rm and carry=Rm[WIDTH-1], with latency 1.
- ASR fill uses the latched sign bit. ROR wraps bits from the low end to the high end on each step.
- in_* inputs are ignored outside IDLE.
- Operands are latched, so inputs may change freely after accept.
- out_ready held high while waiting in DONE: the handoff happens in the first DONE cycle.

Optional Feature:
- Macro SHIFT_RRX_EN.
- Defined: ROR with amt==0 performs RRX. out_data={in_carry, Rm[WIDTH-1:1]}, out_carry=Rm[0], latency 2 (one BUSY step).
- Undefined: ROR with amt==0 follows the amt==0 pass-through rule above.

Test Plan:
- Reset: assert rst_n=0 mid-BUSY of LSL 0x1 by 20 -> out_valid=0, in_ready=1 immediately; no output after release.
- LSL 0x80000001 by 1, STEP=4 -> out_data=0x00000002, out_carry=1, out_valid at cycle 2.
- LSR 0x80000000 by 32 -> out_data=0, out_carry=1. LSR same by 33 -> out_data=0, out_carry=0; latency 1+ceil(33/4)=10.
- ASR 0x80000000 by 200 -> out_data=0xFFFFFFFF, out_carry=1. ASR 0x40000000 by 31 -> out_data=0, out_carry=1.
- ROR 0x000000F1 by 36 -> out_data=0x1000000F, out_carry=0. ROR by 32 -> data unchanged, carry=Rm[31]. Hold out_ready=0 for 5 cycles -> output stable, in_ready=0.
- amt=0 LSL with in_carry=1 -> pass-through, out_carry=1, latency 1. With SHIFT_RRX_EN: ROR 0x00000003 by 0, in_carry=1 -> out_data=0x80000001, out_carry=1.
